// File: rtl/ms_timer_pkg.sv
// Shared types and constants for millisecond timer blocks.
package ms_timer_pkg;

    // Countdown controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } ms_state_t;

    // Default millisecond count width (max interval 65535 ms)
    localparam int unsigned MS_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a signal already synchronous to clk.
// The history register resets high so a signal that is already high at
// reset release does not produce a spurious tick.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic tick
);

    logic prev;

    // Remember last cycle's level of sig
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else begin
            prev <= sig;
        end
    end

    assign tick = sig & ~prev;

endmodule

// File: rtl/ms_countdown.sv
// Programmable millisecond countdown timer driven by the 1 kHz ms clock.
// Supports load/restart, pause/resume, clear, one-shot or periodic reload,
// and a one-cycle Done pulse on expiry. All outputs are registered.
module ms_countdown
    import ms_timer_pkg::*;
#(
    parameter int unsigned WIDTH       = MS_WIDTH_DEFAULT,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             msClock,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Clear,
    input  logic [WIDTH-1:0] LoadValue,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Remaining
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    ms_state_t        state;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] reload;
    logic             done;
    logic             busy;
    logic             tick;

    rise_detect u_rise_detect (
        .clk   (Clock),
        .rst_n (Resetn),
        .sig   (msClock),
        .tick  (tick)
    );

    // Controller FSM; priority per cycle is Clear > Start > Stop > tick
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            remaining <= ZERO;
            reload    <= ZERO;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (Clear) begin
                state     <= IDLE;
                remaining <= ZERO;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Start) begin
                            if (LoadValue != ZERO) begin
                                remaining <= LoadValue;
                                reload    <= LoadValue;
                                state     <= RUN;
                                busy      <= 1'b1;
                            end else begin
                                // Zero-length interval expires immediately
                                done <= 1'b1;
                            end
                        end
                    end

                    RUN: begin
                        if (Start) begin
                            // Restart; any tick in this cycle is discarded
                            remaining <= LoadValue;
                            reload    <= LoadValue;
                            if (LoadValue == ZERO) begin
                                done  <= 1'b1;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (Stop) begin
                            state <= PAUSED;
                        end else if (tick) begin
                            if (remaining > ONE) begin
                                remaining <= remaining - ONE;
                            end else if (remaining == ONE) begin
                                done <= 1'b1;
                                if (AUTO_RELOAD) begin
                                    remaining <= reload;
                                end else begin
                                    remaining <= ZERO;
                                    state     <= IDLE;
                                    busy      <= 1'b0;
                                end
                            end
                        end
                    end

                    PAUSED: begin
                        // Resume without reloading; Stop and ticks ignored
                        if (Start) begin
                            state <= RUN;
                        end
                    end

                    default: begin
                        state     <= IDLE;
                        remaining <= ZERO;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Busy      = busy;
    assign Done      = done;
    assign Remaining = remaining;

endmodule

// File: tb/tb_ms_countdown.sv
// Directed self-checking bench for ms_countdown (one-shot and periodic).
module tb_ms_countdown;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ms_clock;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] load_value = '0;

    logic         busy_os, done_os;
    logic [W-1:0] rem_os;
    logic         busy_ar, done_ar;
    logic [W-1:0] rem_ar;

    int unsigned  ms_cnt = 0;
    int unsigned  cyc = 0;
    int unsigned  done_os_cnt = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    ms_countdown #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_dut_os (
        .Clock     (clk),
        .Resetn    (rst_n),
        .msClock   (ms_clock),
        .Start     (start),
        .Stop      (stop),
        .Clear     (clear),
        .LoadValue (load_value),
        .Busy      (busy_os),
        .Done      (done_os),
        .Remaining (rem_os)
    );

    ms_countdown #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_dut_ar (
        .Clock     (clk),
        .Resetn    (rst_n),
        .msClock   (ms_clock),
        .Start     (start),
        .Stop      (stop),
        .Clear     (clear),
        .LoadValue (load_value),
        .Busy      (busy_ar),
        .Done      (done_ar),
        .Remaining (rem_ar)
    );

    always #5 clk = ~clk;

    // ms clock with a 20-cycle period, high for counts 0..9
    always @(posedge clk) begin
        ms_cnt <= (ms_cnt == 19) ? 0 : ms_cnt + 1;
        cyc    <= cyc + 1;
        if (done_os) done_os_cnt <= done_os_cnt + 1;
    end
    assign ms_clock = (ms_cnt < 10);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next edge on which the DUT sees a tick
    task automatic wait_tick();
        int n = 0;
        while (ms_cnt != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tick_wait_bound", 32'(n < 40), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [W-1:0] lv);
        @(negedge clk);
        start = 1'b1;
        load_value = lv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        int unsigned d0;
        int unsigned t0;
        int n;

        // Reset held with msClock high, then released while still high
        repeat (3) @(negedge clk);
        check("rst_rem", 32'(rem_os), 0);
        check("rst_busy", 32'(busy_os), 0);
        rst_n = 1'b1;
        d0 = done_os_cnt;
        repeat (100) @(negedge clk);
        check("rst_no_done", done_os_cnt - d0, 0);
        check("rst_rem_hold", 32'(rem_os), 0);
        check("rst_busy_hold", 32'(busy_os), 0);
        check("rst_done_hold", 32'(done_os), 0);

        // One-shot countdown from 3
        d0 = done_os_cnt;
        pulse_start(16'd3);
        check("os_load_rem", 32'(rem_os), 3);
        check("os_load_busy", 32'(busy_os), 1);
        wait_tick();
        check("os_rem2", 32'(rem_os), 2);
        check("os_done_early", 32'(done_os), 0);
        wait_tick();
        check("os_rem1", 32'(rem_os), 1);
        wait_tick();
        check("os_rem0", 32'(rem_os), 0);
        check("os_done", 32'(done_os), 1);
        check("os_busy_drop", 32'(busy_os), 0);
        @(posedge clk);
        #1;
        check("os_done_one_cycle", 32'(done_os), 0);
        repeat (3) @(negedge clk);
        check("os_done_count", done_os_cnt - d0, 1);

        // Pause after two ticks, hold three periods, resume without reload
        pulse_start(16'd5);
        wait_tick();
        wait_tick();
        check("pz_rem3", 32'(rem_os), 3);
        pulse_stop();
        check("pz_busy", 32'(busy_os), 1);
        repeat (60) @(negedge clk);
        check("pz_rem_hold", 32'(rem_os), 3);
        check("pz_busy_hold", 32'(busy_os), 1);
        pulse_start(16'd9);
        check("pz_resume_no_reload", 32'(rem_os), 3);
        wait_tick();
        check("pz_rem2", 32'(rem_os), 2);
        wait_tick();
        check("pz_rem1", 32'(rem_os), 1);
        wait_tick();
        check("pz_rem0", 32'(rem_os), 0);
        check("pz_done", 32'(done_os), 1);
        check("pz_busy_drop", 32'(busy_os), 0);

        // Start with zero load from IDLE: immediate single Done
        @(negedge clk);
        pulse_start(16'd0);
        check("z_done", 32'(done_os), 1);
        check("z_busy", 32'(busy_os), 0);
        @(negedge clk);
        check("z_done_drop", 32'(done_os), 0);

        // Clear and Start together while running
        pulse_start(16'd7);
        check("cs_running", 32'(busy_os), 1);
        @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        load_value = 16'd4;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        check("cs_busy", 32'(busy_os), 0);
        check("cs_rem", 32'(rem_os), 0);
        check("cs_no_done", 32'(done_os), 0);

        // Restart coincident with a tick: reload, no decrement
        pulse_start(16'd6);
        wait_tick();
        check("st_rem5", 32'(rem_os), 5);
        n = 0;
        while (ms_cnt != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("st_align_bound", 32'(n < 40), 1);
        start = 1'b1;
        load_value = 16'd8;
        @(posedge clk);
        #1;
        check("st_reload", 32'(rem_os), 8);
        @(negedge clk);
        start = 1'b0;
        wait_tick();
        check("st_rem7", 32'(rem_os), 7);

        // Asynchronous reset mid-count
        @(negedge clk);
        d0 = done_os_cnt;
        rst_n = 1'b0;
        #1;
        check("ar_rst_rem", 32'(rem_os), 0);
        check("ar_rst_busy", 32'(busy_os), 0);
        check("ar_rst_done", 32'(done_os), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("ar_rst_no_done", done_os_cnt - d0, 0);
        check("ar_rst_rem_hold", 32'(rem_os), 0);

        // Periodic mode with load 2: Done every 40 cycles, sequence 2,1,2,1
        pulse_start(16'd2);
        check("pr_rem2", 32'(rem_ar), 2);
        check("pr_busy", 32'(busy_ar), 1);
        wait_tick();
        check("pr_rem1", 32'(rem_ar), 1);
        check("pr_no_done", 32'(done_ar), 0);
        wait_tick();
        check("pr_reload", 32'(rem_ar), 2);
        check("pr_done1", 32'(done_ar), 1);
        check("pr_busy_keep", 32'(busy_ar), 1);
        t0 = cyc;
        @(posedge clk);
        #1;
        check("pr_done_drop", 32'(done_ar), 0);
        wait_tick();
        check("pr_rem1_b", 32'(rem_ar), 1);
        wait_tick();
        check("pr_done2", 32'(done_ar), 1);
        check("pr_reload_b", 32'(rem_ar), 2);
        check("pr_period", cyc - t0, 40);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("pr_clear_busy", 32'(busy_ar), 0);
        check("pr_clear_rem", 32'(rem_ar), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
